mesh_result_drain: RTL and testbench

//  Downstream of the sorting mesh: after SORT_CYCLES, sequentially reads each PE's final

---
 rtl/mesh_result_drain_pkg.sv | 21 ++
 rtl/mesh_result_drain_fifo.sv | 60 ++++++
 rtl/mesh_result_drain.sv | 177 +++++++++++++++++
 tb/tb_mesh_result_drain.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_result_drain_pkg.sv
// Shared constants for the mesh result drain: default field widths, result-word
// layout and FSM encoding.
package mesh_result_drain_pkg;

  localparam int DRAIN_DATA_WIDTH = 32;
  localparam int DRAIN_ADDR_WIDTH = 8;
  localparam int DRAIN_WIDTH      = DRAIN_ADDR_WIDTH + DRAIN_DATA_WIDTH;

  // Result word layout: {flag, addr, data}
  localparam int DRAIN_FLAG_BIT   = DRAIN_WIDTH;
  localparam int DRAIN_ADDR_HI    = DRAIN_WIDTH - 1;
  localparam int DRAIN_ADDR_LO    = DRAIN_DATA_WIDTH;
  localparam int DRAIN_DATA_HI    = DRAIN_DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2
  } drain_state_e;

endpackage

// File: rtl/mesh_result_drain_fifo.sv
// Two-entry FIFO holding captured result words between the mesh read port and
// the downstream valid/ready interface. Push and pop may share a cycle.
module drain_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              do_push, do_pop;

  always_comb begin
    do_pop  = pop && (cnt_q != 2'd0);
    // a full FIFO still accepts a push when the head leaves the same cycle
    do_push = push && ((cnt_q != 2'd2) || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = ~wr_q;
    end
    if (do_pop) rd_d = ~rd_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/mesh_result_drain.sv
// Sequential readout of the sorting mesh results: reads each PE word in index
// order, checks flag/address/ordering, and streams it out over valid/ready.
module mesh_result_drain
  import mesh_result_drain_pkg::*;
#(
  parameter int DATA_WIDTH = DRAIN_DATA_WIDTH,
  parameter int ADDR_WIDTH = DRAIN_ADDR_WIDTH,
  parameter int N          = 256,
  parameter int DESCENDING = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           rd_en,
  output logic [ADDR_WIDTH-1:0]          rd_idx,
  input  logic [ADDR_WIDTH+DATA_WIDTH:0] rd_word,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ADDR_WIDTH-1:0]          out_addr,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_last,
  output logic                           err_flag,
  output logic [ADDR_WIDTH:0]            err_count,
  output logic [ADDR_WIDTH-1:0]          first_err_idx
);

  localparam int                    WIDTH    = ADDR_WIDTH + DATA_WIDTH;
  localparam int                    ENT_W    = WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_MAX  = '1;

  drain_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  infl_q, infl_d;
  logic [ADDR_WIDTH-1:0] infl_idx_q, infl_idx_d;
  logic [DATA_WIDTH-1:0] prev_data_q, prev_data_d;
  logic                  err_flag_q, err_flag_d;
  logic [ADDR_WIDTH:0]   err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0] first_err_q, first_err_d;
  logic                  done_q, done_d;

  logic                  w_flag;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [ENT_W-1:0]      head;
  logic [ADDR_WIDTH-1:0] head_idx;
  logic                  fifo_full, fifo_empty;
  logic [1:0]            fifo_occ;
  logic [2:0]            occ_after;
  logic                  pop, issue_ok, head_last;
  logic                  order_bad, word_fail;

  assign w_flag = rd_word[WIDTH];
  assign w_addr = rd_word[WIDTH-1:DATA_WIDTH];
  assign w_data = rd_word[DATA_WIDTH-1:0];

  drain_fifo2 #(.W(ENT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (infl_q),
    .pop   (pop),
    .din   ({w_addr, w_data, infl_idx_q}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_idx  = head[ADDR_WIDTH-1:0];
  assign out_valid = !fifo_empty;
  assign out_addr  = head[ENT_W-1:ENT_W-ADDR_WIDTH];
  assign out_data  = head[ADDR_WIDTH+DATA_WIDTH-1:ADDR_WIDTH];
  assign head_last = (head_idx == LAST_IDX);
  assign out_last  = out_valid && head_last;
  assign pop       = out_valid && out_ready;

  // Occupancy the FIFO will hold after this edge; a read issued now lands on
  // the following edge, so it may only go out while that figure is below 2.
  assign fifo_occ  = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign occ_after = {1'b0, fifo_occ} + {2'b0, infl_q} - {2'b0, pop};
  assign issue_ok  = (occ_after < 3'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_READ;
      ST_READ:  if (rd_en && (ptr_q == LAST_IDX)) state_d = ST_FLUSH;
      ST_FLUSH: if (pop && head_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_en = (state_q == ST_READ) && issue_ok;
    busy  = (state_q != ST_IDLE) || done_q;
  end

  assign rd_idx        = ptr_q;
  assign done          = done_q;
  assign err_flag      = err_flag_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_q;

  always_comb begin
    ptr_d      = ptr_q;
    infl_d     = rd_en;
    infl_idx_d = infl_idx_q;
    done_d     = (state_q == ST_FLUSH) && pop && head_last;
    if ((state_q == ST_IDLE) && start) ptr_d = '0;
    if (rd_en) begin
      infl_idx_d = ptr_q;
      if (ptr_q != LAST_IDX) ptr_d = ptr_q + PTR_ONE;
    end
  end

  // Integrity check applied to the word landing this cycle
  always_comb begin
    if (DESCENDING != 0) order_bad = (w_data > prev_data_q);
    else                 order_bad = (w_data < prev_data_q);
    word_fail = w_flag || (w_addr != infl_idx_q) ||
                ((infl_idx_q != '0) && order_bad);
  end

  always_comb begin
    prev_data_d = prev_data_q;
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    if ((state_q == ST_IDLE) && start) begin
      prev_data_d = '0;
      err_flag_d  = 1'b0;
      err_count_d = '0;
      first_err_d = '0;
    end else if (infl_q) begin
      prev_data_d = w_data;
      if (word_fail) begin
        if (err_count_q != CNT_MAX) err_count_d = err_count_q + CNT_ONE;
        if (!err_flag_q) begin
          err_flag_d  = 1'b1;
          first_err_d = infl_idx_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      infl_q      <= 1'b0;
      infl_idx_q  <= '0;
      prev_data_q <= '0;
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
      first_err_q <= '0;
      done_q      <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      infl_q      <= infl_d;
      infl_idx_q  <= infl_idx_d;
      prev_data_q <= prev_data_d;
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_mesh_result_drain.sv
// Directed bench for mesh_result_drain: a mesh memory model answers reads, a
// scoreboard queue holds expected output words, monitors check the handshake.
module tb_mesh_result_drain;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int N  = 256;
  localparam int W  = AW + DW;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, rd_en;
  logic [AW-1:0] rd_idx;
  logic [W:0]    rd_word = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          err_flag;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_idx;

  logic [W:0] mem [N];
  exp_t       exp_q [$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         mode = 0;
  int         n_out = 0;
  int         n_done = 0;
  int         issued = 0;
  int         accepted = 0;

  mesh_result_drain #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N(N), .DESCENDING(1)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_word(rd_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last), .err_flag(err_flag),
    .err_count(err_count), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd_en) rd_word <= mem[rd_idx];

  always @(posedge clk) begin
    #1;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pop, stall stability, read-issue headroom
  logic          stall_q = 1'b0;
  logic [AW-1:0] hold_a;
  logic [DW-1:0] hold_d;
  logic          hold_l;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      exp_q.delete();
      issued   = 0;
      accepted = 0;
      stall_q  = 1'b0;
    end else begin
      if (stall_q)
        chk("stall_stable", 64'({out_valid, out_addr, out_data, out_last}),
            64'({1'b1, hold_a, hold_d, hold_l}));
      if (rd_en) begin
        chk("rd_headroom", 64'((issued - accepted - ((out_valid && out_ready) ? 1 : 0)) < 2), 64'(1));
        issued++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_word", 64'(exp_q.size()), 64'(1));
        else begin
          e = exp_q.pop_front();
          chk("word", 64'({out_addr, out_data, out_last}), 64'({e.a, e.d, e.l}));
        end
        accepted++;
        n_out++;
      end
      if (done) n_done++;
      stall_q = out_valid && !out_ready;
      hold_a  = out_addr;
      hold_d  = out_data;
      hold_l  = out_last;
    end
  end

  task automatic load_sorted();
    for (int i = 0; i < N; i++) mem[i] = {1'b0, AW'(i), DW'(255 - i)};
  endtask

  task automatic push_exp();
    for (int i = 0; i < N; i++) begin
      exp_t e;
      e.a = mem[i][W-1:DW];
      e.d = mem[i][DW-1:0];
      e.l = (i == N - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(output int s);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 s = cyc; start = 1'b0;
  endtask

  task automatic wait_done(output bit got, output int dc);
    got = 0;
    dc  = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin got = 1; dc = cyc; break; end
    end
  endtask

  task automatic check_drain(input string tag, input int base, input logic ef,
                             input int ec, input int fi);
    chk({tag, "_nwords"}, 64'(n_out - base), 64'(N));
    chk({tag, "_qempty"}, 64'(exp_q.size()), 64'(0));
    chk({tag, "_err_flag"}, 64'(err_flag), 64'(ef));
    chk({tag, "_err_count"}, 64'(err_count), 64'(ec));
    chk({tag, "_first_err"}, 64'(first_err_idx), 64'(fi));
  endtask

  task automatic run_drain(input string tag, input logic ef, input int ec, input int fi);
    int  base, s, dc;
    bit  got;
    base = n_out;
    push_exp();
    pulse_start(s);
    wait_done(got, dc);
    chk({tag, "_done_seen"}, 64'(got), 64'(1));
    @(negedge clk);
    check_drain(tag, base, ef, ec, fi);
  endtask

  initial begin
    int  s, s2, dc, base, nd;
    bit  got, reached;
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({busy, done, rd_en, out_valid, out_last, err_flag}), 64'(0));
    chk("rst_idx", 64'({rd_idx, out_addr, first_err_idx, err_count}), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: clean sorted drain, full throughput, latency checks
    load_sorted();
    base = n_out;
    push_exp();
    pulse_start(s);
    @(negedge clk); chk("t1_busy", 64'(busy), 64'(1));
    @(negedge clk); chk("t1_vld_early", 64'(out_valid), 64'(0));
    @(negedge clk); chk("t1_vld_first", 64'(out_valid), 64'(1));
    wait_done(got, dc);
    chk("t1_done_seen", 64'(got), 64'(1));
    chk("t1_done_lat", 64'(dc - s), 64'(N + 2));
    chk("t1_busy_at_done", 64'(busy), 64'(1));
    @(negedge clk);
    chk("t1_idle", 64'({busy, done}), 64'(0));
    check_drain("t1", base, 1'b0, 0, 0);

    // 2: toggling ready, then random stalls
    mode = 1;
    run_drain("t2a", 1'b0, 0, 0);
    mode = 2;
    run_drain("t2b", 1'b0, 0, 0);
    mode = 0;

    // 3: flag error at 17, address error at 40
    load_sorted();
    mem[17][W] = 1'b1;
    mem[40][W-1:DW] = AW'(41);
    run_drain("t3", 1'b1, 2, 17);

    // 4: ordering broken at 100/101; new start must clear t3's counters
    load_sorted();
    mem[100][DW-1:0] = DW'(154);
    mem[101][DW-1:0] = DW'(155);
    run_drain("t4", 1'b1, 1, 101);

    // 5: reset in the middle of a drain that already saw an error
    load_sorted();
    mem[5][W] = 1'b1;
    base = n_out;
    push_exp();
    pulse_start(s);
    reached = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (n_out - base >= 60) begin reached = 1; break; end
    end
    chk("t5_reached_60", 64'(reached), 64'(1));
    chk("t5_err_before", 64'(err_flag), 64'(1));
    nd = n_done;
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_ctrl", 64'({busy, done, rd_en, out_valid, out_last, err_flag}), 64'(0));
    chk("t5_rst_idx", 64'({rd_idx, out_addr, first_err_idx, err_count}), 64'(0));
    chk("t5_rst_data", 64'(out_data), 64'(0));
    repeat (5) @(negedge clk);
    chk("t5_no_done", 64'(n_done - nd), 64'(0));
    rst = 1'b1;
    load_sorted();
    run_drain("t5_after", 1'b0, 0, 0);

    // 6: second start while busy is ignored
    load_sorted();
    base = n_out;
    nd   = n_done;
    push_exp();
    pulse_start(s);
    repeat (20) @(negedge clk);
    pulse_start(s2);
    wait_done(got, dc);
    chk("t6_done_seen", 64'(got), 64'(1));
    chk("t6_done_lat", 64'(dc - s), 64'(N + 2));
    repeat (10) @(negedge clk);
    chk("t6_one_done", 64'(n_done - nd), 64'(1));
    chk("t6_busy_idle", 64'(busy), 64'(0));
    check_drain("t6", base, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
